// File: rtl/dac_scan_sequencer.sv
// dac_scan_sequencer
//   Steps a DAC through a code ramp. For each point it loads the code into the
//   DAC master, waits for the load acknowledge, lets the output settle, opens a
//   counter gate window and reports the completed point. The scan ends when the
//   next code would pass the stop code or the top of the code range.
//
// Ports
//   clk          single clock for all logic
//   nres         asynchronous active-low reset
//   cfg_start    first scan code
//   cfg_stop     last allowed scan code
//   cfg_step     code increment (0 gives a single point)
//   cfg_settle   DAC settle cycles (0 treated as 1)
//   cfg_gate     counter gate cycles (0 treated as 1)
//   cmd_start    one-cycle scan start request (IDLE only)
//   cmd_abort    one-cycle abort request (wins over cmd_start)
//   dac_code     code presented to the DAC master
//   dac_req      one-cycle DAC load request
//   dac_ack      DAC load complete pulse
//   gate         counter enable window
//   point_valid  one-cycle pulse for a completed point
//   point_code   code of the completed point
//   point_idx    zero-based point index
//   busy         scan in progress
//   done         one-cycle pulse on normal scan completion
//   err          sticky ack-timeout flag, cleared by the next accepted start
module dac_scan_sequencer #(
    parameter int CODE_W      = 12,
    parameter int TIME_W      = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nres,
    input  logic [CODE_W-1:0] cfg_start,
    input  logic [CODE_W-1:0] cfg_stop,
    input  logic [CODE_W-1:0] cfg_step,
    input  logic [TIME_W-1:0] cfg_settle,
    input  logic [TIME_W-1:0] cfg_gate,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    output logic [CODE_W-1:0] dac_code,
    output logic              dac_req,
    input  logic              dac_ack,
    output logic              gate,
    output logic              point_valid,
    output logic [CODE_W-1:0] point_code,
    output logic [CODE_W-1:0] point_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One shared timer serves the ack timeout and the settle/gate windows.
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int TMR_W = (TIME_W > ACK_W) ? TIME_W : ACK_W;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_ACK, SETTLE, GATE, REPORT, NEXT
    } state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n, timer_inc;
    logic [CODE_W-1:0] stop_l, stop_n;
    logic [CODE_W-1:0] step_l, step_n;
    logic [TIME_W-1:0] settle_l, settle_n;
    logic [TIME_W-1:0] gate_l, gate_n;
    logic [CODE_W-1:0] dac_code_n, point_code_n, point_idx_n;
    logic              done_n, err_n;
    logic [CODE_W:0]   sum;

    function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] v);
        return (v == '0) ? TIME_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state       <= IDLE;
            timer       <= '0;
            stop_l      <= '0;
            step_l      <= '0;
            settle_l    <= '0;
            gate_l      <= '0;
            dac_code    <= '0;
            dac_req     <= 1'b0;
            gate        <= 1'b0;
            point_valid <= 1'b0;
            point_code  <= '0;
            point_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            stop_l      <= stop_n;
            step_l      <= step_n;
            settle_l    <= settle_n;
            gate_l      <= gate_n;
            dac_code    <= dac_code_n;
            point_code  <= point_code_n;
            point_idx   <= point_idx_n;
            done        <= done_n;
            err         <= err_n;
            // Strobes are registered copies of the state being entered, so
            // they line up exactly with the cycles spent in that state.
            dac_req     <= (state_n == LOAD);
            gate        <= (state_n == GATE);
            point_valid <= (state_n == REPORT);
            busy        <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        stop_n       = stop_l;
        step_n       = step_l;
        settle_n     = settle_l;
        gate_n       = gate_l;
        dac_code_n   = dac_code;
        point_code_n = point_code;
        point_idx_n  = point_idx;
        done_n       = 1'b0;
        err_n        = err;
        timer_inc    = timer + TMR_W'(1);
        // Extra bit catches overflow past the top code.
        sum          = {1'b0, dac_code} + {1'b0, step_l};

        case (state)
            IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    stop_n      = cfg_stop;
                    step_n      = cfg_step;
                    settle_n    = at_least_one(cfg_settle);
                    gate_n      = at_least_one(cfg_gate);
                    dac_code_n  = cfg_start;
                    point_idx_n = '0;
                    err_n       = 1'b0;
                    timer_n     = '0;
                    state_n     = LOAD;
                end
            end
            LOAD: begin
                timer_n = '0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (dac_ack) begin
                    timer_n = '0;
                    state_n = SETTLE;
                end else if (timer_inc == TMR_W'(ACK_TIMEOUT)) begin
                    err_n   = 1'b1;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_inc;
                end
            end
            SETTLE: begin
                if (timer_inc == TMR_W'(settle_l)) begin
                    timer_n = '0;
                    state_n = GATE;
                end else begin
                    timer_n = timer_inc;
                end
            end
            GATE: begin
                if (timer_inc == TMR_W'(gate_l)) begin
                    timer_n      = '0;
                    point_code_n = dac_code;
                    state_n      = REPORT;
                end else begin
                    timer_n = timer_inc;
                end
            end
            REPORT: begin
                state_n = NEXT;
            end
            NEXT: begin
                if ((step_l == '0) || (sum > {1'b0, stop_l}) || sum[CODE_W]) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    dac_code_n  = sum[CODE_W-1:0];
                    point_idx_n = point_idx + CODE_W'(1);
                    state_n     = LOAD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided; reported data holds.
        if ((state != IDLE) && cmd_abort) begin
            state_n      = IDLE;
            timer_n      = '0;
            done_n       = 1'b0;
            err_n        = err;
            dac_code_n   = dac_code;
            point_code_n = point_code;
            point_idx_n  = point_idx;
        end
    end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Directed bench for dac_scan_sequencer. Stimulus pushes the expected points,
// gate lengths and done pulses; a negedge monitor pops and compares them as
// the DUT produces them.
module tb_dac_scan_sequencer;

    localparam int CW = 12;
    localparam int TW = 16;

    logic          clk;
    logic          nres;
    logic [CW-1:0] cfg_start, cfg_stop, cfg_step;
    logic [TW-1:0] cfg_settle, cfg_gate;
    logic          cmd_start, cmd_abort;
    logic [CW-1:0] dac_code;
    logic          dac_req, dac_ack, gate, point_valid;
    logic [CW-1:0] point_code, point_idx;
    logic          busy, done, err;

    dac_scan_sequencer #(.CODE_W(CW), .TIME_W(TW), .ACK_TIMEOUT(1024)) dut (
        .clk        (clk),
        .nres       (nres),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_step   (cfg_step),
        .cfg_settle (cfg_settle),
        .cfg_gate   (cfg_gate),
        .cmd_start  (cmd_start),
        .cmd_abort  (cmd_abort),
        .dac_code   (dac_code),
        .dac_req    (dac_req),
        .dac_ack    (dac_ack),
        .gate       (gate),
        .point_valid(point_valid),
        .point_code (point_code),
        .point_idx  (point_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [CW-1:0] code;
        logic [CW-1:0] idx;
    } pt_t;

    pt_t exp_pts[$];
    int  exp_gate[$];
    int  exp_done;
    int  n_checks;
    int  n_errors;
    bit  ack_en;
    int  gate_run;
    pt_t mon_p;
    int  mon_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dac_code"}, dac_code, 0);
        chk({tag, "_dac_req"}, dac_req, 0);
        chk({tag, "_gate"}, gate, 0);
        chk({tag, "_point_valid"}, point_valid, 0);
        chk({tag, "_point_code"}, point_code, 0);
        chk({tag, "_point_idx"}, point_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic push_pt(input int code, input int idx, input int glen);
        pt_t t;
        t.code = code[CW-1:0];
        t.idx  = idx[CW-1:0];
        exp_pts.push_back(t);
        exp_gate.push_back(glen);
    endtask

    task automatic start_scan(input int s, input int st, input int sp, input int se, input int g);
        @(posedge clk); #1;
        cfg_start  = s[CW-1:0];
        cfg_stop   = st[CW-1:0];
        cfg_step   = sp[CW-1:0];
        cfg_settle = se[TW-1:0];
        cfg_gate   = g[TW-1:0];
        cmd_start  = 1'b1;
        @(posedge clk); #1;
        cmd_start  = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        @(negedge clk); #1;
        chk({tag, "_pts_left"}, exp_pts.size(), 0);
        chk({tag, "_gates_left"}, exp_gate.size(), 0);
        chk({tag, "_done_left"}, exp_done, 0);
    endtask

    task automatic wait_gate(input logic val, input int max_cyc);
        int n;
        n = 0;
        while (gate !== val && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_gate", gate, val);
    endtask

    // DAC master model: acknowledge each load two cycles after dac_req.
    initial begin
        dac_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dac_req && ack_en) begin
                repeat (2) @(posedge clk);
                #1 dac_ack = 1'b1;
                @(posedge clk); #1;
                dac_ack = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!nres) begin
            gate_run = 0;
        end else begin
            if (point_valid) begin
                if (exp_pts.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL point_unexpected: got code %0d idx %0d required no point", point_code, point_idx);
                end else begin
                    mon_p = exp_pts.pop_front();
                    chk("point_code", point_code, mon_p.code);
                    chk("point_idx", point_idx, mon_p.idx);
                end
            end
            if (done) begin
                chk("done_expected", (exp_done > 0) ? 1 : 0, 1);
                if (exp_done > 0) exp_done--;
            end
            if (gate) begin
                gate_run++;
            end else if (gate_run > 0) begin
                if (exp_gate.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL gate_unexpected: got window of %0d cycles required none", gate_run);
                end else begin
                    mon_g = exp_gate.pop_front();
                    chk("gate_len", gate_run, mon_g);
                end
                gate_run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1);
    end

    initial begin
        int cnt;
        n_checks   = 0;
        n_errors   = 0;
        exp_done   = 0;
        gate_run   = 0;
        ack_en     = 1'b1;
        nres       = 1'b0;
        cfg_start  = '0;
        cfg_stop   = '0;
        cfg_step   = '0;
        cfg_settle = '0;
        cfg_gate   = '0;
        cmd_start  = 1'b0;
        cmd_abort  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        nres = 1'b1;

        // Basic ramp, with a mid-scan start carrying different cfg that must be ignored
        push_pt(100, 0, 5); push_pt(110, 1, 5); push_pt(120, 2, 5); push_pt(130, 3, 5);
        exp_done = 1;
        start_scan(100, 130, 10, 3, 5);
        repeat (3) begin @(posedge clk); #1; end
        cfg_start = '0; cfg_stop = 12'd4095; cfg_step = 12'd1; cfg_gate = 16'd9;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        wait_idle("ramp", 500);
        chk("ramp_err", err, 0);

        // Top of code range: no wrap
        push_pt(4090, 0, 2); push_pt(4094, 1, 2);
        exp_done = 1;
        start_scan(4090, 4095, 4, 1, 2);
        wait_idle("top", 300);

        // Step zero, zero settle/gate treated as one cycle
        push_pt(0, 0, 1);
        exp_done = 1;
        start_scan(0, 50, 0, 0, 0);
        wait_idle("step0", 200);

        // Start above stop: single point
        push_pt(200, 0, 2);
        exp_done = 1;
        start_scan(200, 100, 5, 2, 2);
        wait_idle("inv", 200);

        // Ack timeout
        ack_en = 1'b0;
        start_scan(500, 600, 10, 1, 1);
        chk("to_dac_req", dac_req, 1);
        @(negedge clk);
        cnt = 0;
        while (!err && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_cycles", cnt, 1025);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        ack_en = 1'b1;

        // Next start clears err
        push_pt(10, 0, 3); push_pt(20, 1, 3);
        exp_done = 1;
        start_scan(10, 20, 10, 2, 3);
        chk("err_cleared", err, 0);
        wait_idle("clr", 300);

        // Abort in the second point's gate window (third gate cycle)
        push_pt(50, 0, 5);
        exp_gate.push_back(3);
        start_scan(50, 90, 20, 2, 5);
        wait_gate(1'b1, 100);
        wait_gate(1'b0, 100);
        wait_gate(1'b1, 100);
        repeat (2) begin @(posedge clk); #1; end
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        chk("abort_gate", gate, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dac_code", dac_code, 70);
        chk("abort_point_code", point_code, 50);
        chk("abort_point_idx", point_idx, 1);
        repeat (10) begin @(posedge clk); #1; end
        wait_idle("abort", 10);

        // Start together with abort in IDLE
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_dac_req", dac_req, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("sa_busy_later", busy, 0);

        // Reset asserted mid-SETTLE, then a start on the first edge after release
        start_scan(300, 400, 50, 20, 2);
        repeat (6) @(negedge clk);
        #1 nres = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk); #1;
        push_pt(5, 0, 1);
        exp_done = 1;
        cfg_start = 12'd5; cfg_stop = 12'd5; cfg_step = 12'd1; cfg_settle = 16'd1; cfg_gate = 16'd1;
        cmd_start = 1'b1;
        nres = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        chk("post_reset_busy", busy, 1);
        wait_idle("postrst", 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
